// File: rtl/l1_mem_arbiter_pkg.sv
// l1_mem_arbiter_pkg
//   Types shared by the L1 refill arbiter and its request slots:
//   FSM state encoding, requester identity and the pending-slot record.
//   ARB_ADDR_W is the block-address width (ICACHE_BLOCK_ADDR_BITS); the
//   arbiter's ADDR_W parameter must match it.
package l1_mem_arbiter_pkg;

    localparam int unsigned ARB_ADDR_W = 26;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_IC = 1'b0,
        SRC_DC = 1'b1
    } arb_src_e;

    typedef struct packed {
        logic                  valid;
        logic [ARB_ADDR_W-1:0] addr;
    } arb_slot_t;

    function automatic arb_src_e arb_other(input arb_src_e s);
        return (s == SRC_IC) ? SRC_DC : SRC_IC;
    endfunction

endpackage

// File: rtl/l1_mem_arbiter_arb_req_slot.sv
// arb_req_slot
//   One pending refill request per requester.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     i_req_valid     request pulse
//     i_req_addr      block address of the request
//     i_clear         this side's request was accepted by memory
//     i_flush         discard the pending request (wins over i_req_valid)
//     o_slot          {valid, addr}
//     o_overflow      sticky: a pulse arrived while the slot was full
module arb_req_slot
    import l1_mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    input  logic [ARB_ADDR_W-1:0] i_req_addr,
    input  logic                  i_clear,
    input  logic                  i_flush,
    output arb_slot_t             o_slot,
    output logic                  o_overflow
);

    arb_slot_t r_slot;
    logic      r_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot     <= '0;
            r_overflow <= 1'b0;
        end else if (i_flush) begin
            r_slot.valid <= 1'b0;
        end else if (i_req_valid) begin
            // A slot being drained this cycle can take the new request.
            if (r_slot.valid && !i_clear) begin
                r_overflow <= 1'b1;
            end else begin
                r_slot.valid <= 1'b1;
                r_slot.addr  <= i_req_addr;
            end
        end else if (i_clear) begin
            r_slot.valid <= 1'b0;
        end
    end

    assign o_slot     = r_slot;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter
//   Shares the single L1 refill channel between the I-cache and D-cache
//   controllers. One pending request per side, one memory transaction in
//   flight, response routed back to its issuer. I-cache flush discards
//   pending and in-flight I-side work; a sticky flag reports memory that
//   does not respond within TIMEOUT_CYCLES.
//   Build option: ARB_IC_PRIORITY_EN -- IC always wins a tie (fixed
//   priority); otherwise ties are resolved round-robin.
//   Ports:
//     clk, reset                   clock, synchronous active-high reset
//     icReqValid_i/icReqAddr_i     I-cache refill request pulse/address
//     icFlush_i                    I-cache flush
//     icRespValid_o                I-side response pulse
//     dcReqValid_i/dcReqAddr_i     D-cache refill request pulse/address
//     dcRespValid_o                D-side response pulse
//     respData_o                   refill line for both response pulses
//     memReqValid_o/Ready_i        memory request handshake
//     memReqAddr_o/memReqSrc_o     request address / source (0 IC, 1 DC)
//     memRespValid_i/Data_i        memory response
//     reqOverflow_o                sticky {dc, ic} slot overflow
//     memTimeout_o                 sticky response timeout
module l1_mem_arbiter
    import l1_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = ARB_ADDR_W,
    parameter int unsigned LINE_W         = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icReqValid_i,
    input  logic [ADDR_W-1:0] icReqAddr_i,
    input  logic              icFlush_i,
    output logic              icRespValid_o,
    input  logic              dcReqValid_i,
    input  logic [ADDR_W-1:0] dcReqAddr_i,
    output logic              dcRespValid_o,
    output logic [LINE_W-1:0] respData_o,
    output logic              memReqValid_o,
    input  logic              memReqReady_i,
    output logic [ADDR_W-1:0] memReqAddr_o,
    output logic              memReqSrc_o,
    input  logic              memRespValid_i,
    input  logic [LINE_W-1:0] memRespData_i,
    output logic [1:0]        reqOverflow_o,
    output logic              memTimeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    arb_src_e          r_grant;
    arb_src_e          w_grant;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_discard;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_timeout;
    logic              r_ic_resp;
    logic              r_dc_resp;
    logic [LINE_W-1:0] r_resp_data;

    arb_slot_t         w_ic_slot;
    arb_slot_t         w_dc_slot;
    logic              w_ic_ovf;
    logic              w_dc_ovf;
    logic              w_ic_pend;
    logic              w_dc_pend;
    logic              w_any_pend;
    logic              w_accept;
    logic              w_resp;
    logic              w_ic_clear;
    logic              w_dc_clear;
`ifndef ARB_IC_PRIORITY_EN
    arb_src_e          r_last_grant;
    logic              w_tie;
`endif

    assign w_accept = (r_state == ISSUE) && memReqReady_i;
    assign w_resp   = (r_state == WAIT_RESP) && memRespValid_i;

    // A flush in this cycle removes the IC request from arbitration.
    assign w_ic_pend  = w_ic_slot.valid && !icFlush_i;
    assign w_dc_pend  = w_dc_slot.valid;
    assign w_any_pend = w_ic_pend || w_dc_pend;

    // After a flush the IC slot may already hold a newer request; the
    // in-flight accept must not erase it.
    assign w_ic_clear = w_accept && (r_grant == SRC_IC) && !r_discard;
    assign w_dc_clear = w_accept && (r_grant == SRC_DC);

    arb_req_slot u_ic_slot (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (icReqValid_i),
        .i_req_addr  (icReqAddr_i),
        .i_clear     (w_ic_clear),
        .i_flush     (icFlush_i),
        .o_slot      (w_ic_slot),
        .o_overflow  (w_ic_ovf)
    );

    arb_req_slot u_dc_slot (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (dcReqValid_i),
        .i_req_addr  (dcReqAddr_i),
        .i_clear     (w_dc_clear),
        .i_flush     (1'b0),
        .o_slot      (w_dc_slot),
        .o_overflow  (w_dc_ovf)
    );

    // Grant selection
`ifdef ARB_IC_PRIORITY_EN
    always_comb begin
        w_grant = w_ic_pend ? SRC_IC : SRC_DC;
    end
`else
    assign w_tie = w_ic_pend && w_dc_pend;

    always_comb begin
        w_grant = SRC_IC;
        if (w_tie) begin
            w_grant = arb_other(r_last_grant);
        end else if (w_dc_pend) begin
            w_grant = SRC_DC;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_any_pend)     w_state_next = ISSUE;
            ISSUE:     if (memReqReady_i)  w_state_next = WAIT_RESP;
            WAIT_RESP: if (memRespValid_i) w_state_next = IDLE;
            default:                       w_state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        memReqValid_o = (r_state == ISSUE);
        memReqAddr_o  = r_req_addr;
        memReqSrc_o   = r_grant;
    end

    // Grant, discard, timeout and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant     <= SRC_IC;
            r_req_addr  <= '0;
            r_discard   <= 1'b0;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
            r_ic_resp   <= 1'b0;
            r_dc_resp   <= 1'b0;
            r_resp_data <= '0;
        end else begin
            if ((r_state == IDLE) && w_any_pend) begin
                r_grant    <= w_grant;
                r_req_addr <= (w_grant == SRC_IC) ? w_ic_slot.addr : w_dc_slot.addr;
            end

            if (w_resp) begin
                r_discard <= 1'b0;
            end else if (icFlush_i && (r_state != IDLE) && (r_grant == SRC_IC)) begin
                r_discard <= 1'b1;
            end

            if (w_accept) begin
                r_cnt <= '0;
            end else if ((r_state == WAIT_RESP) && (r_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Flag on the cycle the counter reaches TIMEOUT_CYCLES.
            if ((r_state == WAIT_RESP) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                r_timeout <= 1'b1;
            end

            r_ic_resp <= w_resp && (r_grant == SRC_IC) && !(r_discard || icFlush_i);
            r_dc_resp <= w_resp && (r_grant == SRC_DC);
            if (w_resp) begin
                r_resp_data <= memRespData_i;
            end
        end
    end

`ifndef ARB_IC_PRIORITY_EN
    // lastGrant moves only on a tie, so a lone request does not disturb
    // the fairness order of the next contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= SRC_DC;
        end else if ((r_state == IDLE) && w_tie) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    assign icRespValid_o = r_ic_resp;
    assign dcRespValid_o = r_dc_resp;
    assign respData_o    = r_resp_data;
    assign reqOverflow_o = {w_dc_ovf, w_ic_ovf};
    assign memTimeout_o  = r_timeout;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
module tb_l1_mem_arbiter;

    localparam int AW = 26;
    localparam int LW = 256;
    localparam int TO = 1023;

    logic          clk;
    logic          reset;
    logic          icReqValid_i;
    logic [AW-1:0] icReqAddr_i;
    logic          icFlush_i;
    logic          icRespValid_o;
    logic          dcReqValid_i;
    logic [AW-1:0] dcReqAddr_i;
    logic          dcRespValid_o;
    logic [LW-1:0] respData_o;
    logic          memReqValid_o;
    logic          memReqReady_i;
    logic [AW-1:0] memReqAddr_o;
    logic          memReqSrc_o;
    logic          memRespValid_i;
    logic [LW-1:0] memRespData_i;
    logic [1:0]    reqOverflow_o;
    logic          memTimeout_o;

    l1_mem_arbiter #(
        .ADDR_W         (AW),
        .LINE_W         (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .icReqValid_i   (icReqValid_i),
        .icReqAddr_i    (icReqAddr_i),
        .icFlush_i      (icFlush_i),
        .icRespValid_o  (icRespValid_o),
        .dcReqValid_i   (dcReqValid_i),
        .dcReqAddr_i    (dcReqAddr_i),
        .dcRespValid_o  (dcRespValid_o),
        .respData_o     (respData_o),
        .memReqValid_o  (memReqValid_o),
        .memReqReady_i  (memReqReady_i),
        .memReqAddr_o   (memReqAddr_o),
        .memReqSrc_o    (memReqSrc_o),
        .memRespValid_i (memRespValid_i),
        .memRespData_i  (memRespData_i),
        .reqOverflow_o  (reqOverflow_o),
        .memTimeout_o   (memTimeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          src;
        logic [AW-1:0] addr;
    } req_t;

    typedef struct {
        logic          src;
        logic [LW-1:0] data;
    } resp_t;

    req_t  exp_req[$];
    resp_t exp_resp[$];

    int checks = 0;
    int errors = 0;
    int ic_pulses = 0;
    int dc_pulses = 0;
    int last_mresp_cyc = -100;

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        logic [31:0]   w;
        l = '0;
        for (int i = 0; i < 8; i++) begin
            w = {6'd0, a} ^ {i[3:0], 28'd0};
            l[i*32 +: 32] = w;
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_txn(input logic src, input logic [AW-1:0] a, input bit with_resp);
        req_t  q;
        resp_t r;
        q.src  = src;
        q.addr = a;
        exp_req.push_back(q);
        if (with_resp) begin
            r.src  = src;
            r.data = line_of(a);
            exp_resp.push_back(r);
        end
    endtask

    task automatic pulse(input logic ic, input logic dc, input logic [AW-1:0] ia, input logic [AW-1:0] da);
        @(posedge clk);
        #1;
        icReqValid_i = ic;
        icReqAddr_i  = ia;
        dcReqValid_i = dc;
        dcReqAddr_i  = da;
        @(posedge clk);
        #1;
        icReqValid_i = 1'b0;
        dcReqValid_i = 1'b0;
    endtask

    // Returns at the clock edge that accepts the request.
    task automatic wait_accept(output logic [AW-1:0] a);
        int n;
        n = 0;
        while (!(memReqValid_o && memReqReady_i) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_within_budget", n < 200, 1);
        a = memReqAddr_o;
        @(posedge clk);
    endtask

    // Memory model: respond lat cycles after the accept cycle.
    task automatic serve(input int lat);
        logic [AW-1:0] a;
        wait_accept(a);
        repeat (lat - 1) @(posedge clk);
        #1;
        memRespValid_i = 1'b1;
        memRespData_i  = line_of(a);
        @(posedge clk);
        #1;
        memRespValid_i = 1'b0;
    endtask

    // Monitor / scoreboard
    initial begin
        req_t  e;
        resp_t r;
        forever begin
            @(negedge clk);
            if (memRespValid_i) last_mresp_cyc = cyc;
            if (memReqValid_o && memReqReady_i) begin
                chk("req_expected", exp_req.size() != 0, 1);
                if (exp_req.size() != 0) begin
                    e = exp_req.pop_front();
                    chk("req_src", memReqSrc_o, e.src);
                    chk("req_addr", memReqAddr_o, e.addr);
                end
            end
            if (icRespValid_o || dcRespValid_o) begin
                chk("resp_onehot", icRespValid_o & dcRespValid_o, 0);
                chk("resp_latency", cyc - last_mresp_cyc, 1);
                chk("resp_expected", exp_resp.size() != 0, 1);
                if (exp_resp.size() != 0) begin
                    r = exp_resp.pop_front();
                    chk("resp_side", dcRespValid_o, r.src);
                    chk("resp_data", respData_o, r.data);
                end
                if (icRespValid_o) ic_pulses++;
                if (dcRespValid_o) dc_pulses++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int ic_before;
        int dc_before;

        reset          = 1'b1;
        icReqValid_i   = 1'b0;
        icReqAddr_i    = '0;
        icFlush_i      = 1'b0;
        dcReqValid_i   = 1'b0;
        dcReqAddr_i    = '0;
        memReqReady_i  = 1'b1;
        memRespValid_i = 1'b0;
        memRespData_i  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_memReqValid", memReqValid_o, 0);
        chk("rst_memReqAddr", memReqAddr_o, 0);
        chk("rst_memReqSrc", memReqSrc_o, 0);
        chk("rst_icResp", icRespValid_o, 0);
        chk("rst_dcResp", dcRespValid_o, 0);
        chk("rst_respData", respData_o, 0);
        chk("rst_overflow", reqOverflow_o, 0);
        chk("rst_timeout", memTimeout_o, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single IC refill, memory latency 5
        expect_txn(1'b0, 26'h100, 1'b1);
        pulse(1'b1, 1'b0, 26'h100, '0);
        @(negedge clk);
        chk("t1_valid_cycle1", memReqValid_o, 0);
        @(negedge clk);
        chk("t1_valid_cycle2", memReqValid_o, 1);
        serve(5);
        repeat (3) @(negedge clk);
        chk("t1_ic_pulses", ic_pulses, 1);
        chk("t1_dc_pulses", dc_pulses, 0);
        chk("t1_data_held", respData_o, line_of(26'h100));

        // Two ties in succession
        expect_txn(1'b0, 26'h111, 1'b1);
        expect_txn(1'b1, 26'h222, 1'b1);
        pulse(1'b1, 1'b1, 26'h111, 26'h222);
        serve(3);
        serve(3);
        repeat (2) @(posedge clk);
`ifdef ARB_IC_PRIORITY_EN
        expect_txn(1'b0, 26'h333, 1'b1);
        expect_txn(1'b1, 26'h444, 1'b1);
`else
        expect_txn(1'b1, 26'h444, 1'b1);
        expect_txn(1'b0, 26'h333, 1'b1);
`endif
        pulse(1'b1, 1'b1, 26'h333, 26'h444);
        serve(3);
        serve(3);
        repeat (3) @(negedge clk);
        chk("rr_resp_drained", exp_resp.size(), 0);

        // Back-pressure: ready low for 4 ISSUE cycles
        memReqReady_i = 1'b0;
        expect_txn(1'b1, 26'h3AB, 1'b1);
        pulse(1'b0, 1'b1, '0, 26'h3AB);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_valid", memReqValid_o, 1);
            chk("bp_addr", memReqAddr_o, 26'h3AB);
            chk("bp_src", memReqSrc_o, 1);
        end
        @(posedge clk);
        #1 memReqReady_i = 1'b1;
        serve(2);
        repeat (3) @(negedge clk);

        // Overflow: second IC pulse while the first is pending
        expect_txn(1'b0, 26'h200, 1'b1);
        @(posedge clk);
        #1;
        icReqValid_i = 1'b1;
        icReqAddr_i  = 26'h200;
        @(posedge clk);
        #1 icReqAddr_i = 26'h300;
        @(posedge clk);
        #1 icReqValid_i = 1'b0;
        serve(2);
        repeat (3) @(negedge clk);
        chk("ovf_flags", reqOverflow_o, 2'b01);

        // Flush during WAIT_RESP of an IC refill
        ic_before = ic_pulses;
        dc_before = dc_pulses;
        expect_txn(1'b0, 26'h150, 1'b0);
        pulse(1'b1, 1'b0, 26'h150, '0);
        wait_accept(a);
        #1 icFlush_i = 1'b1;
        @(posedge clk);
        #1 icFlush_i = 1'b0;
        @(posedge clk);
        #1;
        memRespValid_i = 1'b1;
        memRespData_i  = line_of(a);
        @(posedge clk);
        #1 memRespValid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_no_ic_resp", ic_pulses, ic_before);
        expect_txn(1'b1, 26'h2CD, 1'b1);
        pulse(1'b0, 1'b1, '0, 26'h2CD);
        serve(4);
        repeat (3) @(negedge clk);
        chk("flush_dc_served", dc_pulses, dc_before + 1);

        // Memory never responds
        expect_txn(1'b0, 26'h3FF, 1'b0);
        pulse(1'b1, 1'b0, 26'h3FF, '0);
        wait_accept(a);
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge clk);
            if (k == TO) chk("timeout_not_yet", memTimeout_o, 0);
            if (k == TO + 1) chk("timeout_raised", memTimeout_o, 1);
        end

        // Reset while waiting for the response
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst2_memReqValid", memReqValid_o, 0);
        chk("rst2_memReqAddr", memReqAddr_o, 0);
        chk("rst2_icResp", icRespValid_o, 0);
        chk("rst2_dcResp", dcRespValid_o, 0);
        chk("rst2_respData", respData_o, 0);
        chk("rst2_overflow", reqOverflow_o, 0);
        chk("rst2_timeout", memTimeout_o, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Late response after reset is ignored
        ic_before = ic_pulses;
        dc_before = dc_pulses;
        memRespValid_i = 1'b1;
        memRespData_i  = line_of(26'h3FF);
        @(posedge clk);
        #1 memRespValid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ic_ignored", ic_pulses, ic_before);
        chk("late_dc_ignored", dc_pulses, dc_before);
        chk("late_no_req", memReqValid_o, 0);

        // Normal service after reset
        expect_txn(1'b1, 26'h0AA, 1'b1);
        pulse(1'b0, 1'b1, '0, 26'h0AA);
        serve(1);
        repeat (3) @(negedge clk);
        chk("post_rst_dc_served", dc_pulses, dc_before + 1);

        chk("final_req_queue_empty", exp_req.size(), 0);
        chk("final_resp_queue_empty", exp_resp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
